// File: rtl/gfx_cmd_pkg.sv
// Definitions shared by the command stream producer and command_processor:
// word width, word type and opcode field layout.
package gfx_cmd_pkg;

  localparam int CMD_W = 32;

  typedef logic [CMD_W-1:0] cmd_word_t;

  localparam int CMD_OP_MSB = 31;
  localparam int CMD_OP_LSB = 24;

  typedef enum logic [CMD_OP_MSB-CMD_OP_LSB:0] {
    OP_NOP     = 8'h00,
    OP_DRAW    = 8'h01,
    OP_SET_REG = 8'h02,
    OP_FENCE   = 8'h03
  } cmd_op_e;

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock FIFO with flush; full/empty come from an occupancy counter.
// Read data is the combinational head entry; pop must only be asserted when non-empty.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  wr_data,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  rd_data,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage needs no reset; occupancy decides what is meaningful.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign level   = level_q;
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);

endmodule

// File: rtl/cmd_stream_tx.sv
// Command stream producer: host FIFO feeding a registered valid/ready output stage.
// One-cycle load latency from FIFO to cmd_valid; presented words hold until accepted.
module cmd_stream_tx
  import gfx_cmd_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CMD_W = gfx_cmd_pkg::CMD_W,
  parameter int CNT_W = 16,
  localparam int LW   = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             host_wr_en,
  input  logic [CMD_W-1:0] host_wr_data,
  output logic             host_full,
  input  logic             flush,
  input  logic             pause,
  output logic             cmd_valid,
  output logic [CMD_W-1:0] cmd_data,
  input  logic             cmd_ready,
  output logic [LW-1:0]    fifo_level,
  output logic             overflow,
  output logic [CNT_W-1:0] issued_count,
  output logic             idle
);

  logic             fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [CMD_W-1:0] fifo_head;
  logic [LW-1:0]    fifo_lvl;

  logic             cmd_valid_q, cmd_valid_d;
  logic [CMD_W-1:0] cmd_data_q, cmd_data_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic             xfer, load;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (fifo_push),
    .wr_data (host_wr_data),
    .pop     (fifo_pop),
    .flush   (flush),
    .rd_data (fifo_head),
    .level   (fifo_lvl),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Full is the registered value, so a pop in the same cycle does not make room.
  assign fifo_push = host_wr_en && !fifo_full && !flush;
  assign xfer      = cmd_valid_q && cmd_ready;
  // A flush discards the head too, so it never reaches the output register.
  assign load      = (!cmd_valid_q || cmd_ready) && !fifo_empty && !pause && !flush;
  assign fifo_pop  = load;

  always_comb begin
    cmd_valid_d = cmd_valid_q;
    cmd_data_d  = cmd_data_q;
    overflow_d  = overflow_q;
    issued_d    = issued_q;
    if (load) begin
      cmd_valid_d = 1'b1;
      cmd_data_d  = fifo_head;
    end else if (xfer) begin
      cmd_valid_d = 1'b0;
    end
    if (xfer) issued_d = issued_q + CNT_W'(1);
    if (flush)
      overflow_d = 1'b0;
    else if (host_wr_en && fifo_full)
      overflow_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_data_q  <= '0;
      overflow_q  <= 1'b0;
      issued_q    <= '0;
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_data_q  <= cmd_data_d;
      overflow_q  <= overflow_d;
      issued_q    <= issued_d;
    end
  end

  assign cmd_valid    = cmd_valid_q;
  assign cmd_data     = cmd_data_q;
  assign host_full    = fifo_full;
  assign fifo_level   = fifo_lvl;
  assign overflow     = overflow_q;
  assign issued_count = issued_q;
  assign idle         = fifo_empty && !cmd_valid_q;

endmodule
